// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN convolution engines.
package cnn_pkg;

    typedef enum logic [1:0] {IDLE, ACC, WR} conv_state_t;

    // $clog2 that never returns 0, so single-entry selectors still get one bit
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // ReLU followed by unsigned saturation to out_w bits
    function automatic logic [63:0] relu_sat(input logic signed [63:0] sum,
                                             input int unsigned out_w);
        logic signed [63:0] max_val;
        max_val = (64'sd1 <<< out_w) - 64'sd1;
        if (sum <= 64'sd0) begin
            return 64'd0;
        end
        if (sum > max_val) begin
            return max_val;
        end
        return sum;
    endfunction

endpackage

// File: rtl/conv_out_ram.sv
// Output activation RAM: one write port, one registered read port.
module conv_out_ram
    import cnn_pkg::*;
#(
    parameter int unsigned DEPTH = 676,
    parameter int unsigned WIDTH = 36,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned IW = clog2_safe(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array write; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Registered read; same-address write returns old data, out-of-range reads give 0
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (raddr < AW'(DEPTH)) begin
            rdata <= mem[raddr[IW-1:0]];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/conv_layer_acc.sv
// Convolution layer engine: N_CH parallel MAC channels over N_TAP taps, bias,
// ReLU/saturate, and an internal output RAM of DEPTH packed words.
module conv_layer_acc
    import cnn_pkg::*;
#(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned N_TAP = 9,
    parameter int unsigned DIN_W = 1,
    parameter int unsigned W_W   = 9,
    parameter int unsigned OUT_W = 18,
    parameter int unsigned DEPTH = 676,
    parameter int unsigned AW    = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               strt,
    input  logic                               tx_done,
    input  logic [DIN_W-1:0]                   din,
    output logic [clog2_safe(N_TAP)-1:0]       tap_idx,
    output logic                               bsy,
    output logic                               rdy,
    input  logic                               wt_wr,
    input  logic [clog2_safe(N_CH)-1:0]        wt_ch,
    input  logic [clog2_safe(N_TAP + 1)-1:0]   wt_tap,
    input  logic signed [W_W-1:0]              wt_data,
    input  logic [AW-1:0]                      rd_addr,
    output logic [N_CH*OUT_W-1:0]              dout
);

    localparam int unsigned TAP_W    = clog2_safe(N_TAP);
    localparam int unsigned WT_TAP_W = clog2_safe(N_TAP + 1);
    // Wide enough that N_TAP products of the extremes cannot overflow
    localparam int unsigned ACC_W    = DIN_W + W_W + 1 + $clog2(N_TAP) + 1;
    localparam int unsigned SUM_W    = ACC_W + 1;

    conv_state_t             state;
    logic signed [W_W-1:0]   w     [N_CH][N_TAP];
    logic signed [W_W-1:0]   bias  [N_CH];
    logic signed [ACC_W-1:0] acc   [N_CH];
    logic signed [ACC_W-1:0] prod  [N_CH];
    logic signed [SUM_W-1:0] sums  [N_CH];
    logic [AW-1:0]           wr_addr;
    logic [N_CH*OUT_W-1:0]   wr_word;
    logic                    wr_en;
    logic                    wt_ok;

    // Weight/bias writes only land while idle and for in-range targets
    assign wt_ok = wt_wr && (state == IDLE)
                   && (32'(wt_ch) < N_CH) && (32'(wt_tap) <= N_TAP);

    // A position aborted by reset or tx_done in its WR cycle is never stored
    assign wr_en = (state == WR) && !rst && !tx_done;

    // Per-channel product, bias add and ReLU/saturation of the packed result word
    always_comb begin
        wr_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            prod[c] = ACC_W'($signed({1'b0, din})) * ACC_W'(w[c][tap_idx]);
            sums[c] = SUM_W'(acc[c]) + SUM_W'(bias[c]);
            wr_word[c*OUT_W +: OUT_W] = OUT_W'(relu_sat(64'(sums[c]), OUT_W));
        end
    end

    // Run-time loadable weight and bias tables (not reset)
    always_ff @(posedge clk) begin
        if (wt_ok) begin
            if (wt_tap == WT_TAP_W'(N_TAP)) begin
                bias[wt_ch] <= wt_data;
            end else begin
                w[wt_ch][wt_tap] <= wt_data;
            end
        end
    end

    // Control FSM with registered status outputs and accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_addr <= '0;
            tap_idx <= '0;
            bsy     <= 1'b0;
            rdy     <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                acc[c] <= '0;
            end
        end else if (tx_done) begin
            state   <= IDLE;
            wr_addr <= '0;
            tap_idx <= '0;
            bsy     <= 1'b0;
            rdy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (strt && !rdy) begin
                        state   <= ACC;
                        tap_idx <= '0;
                        bsy     <= 1'b1;
                        for (int c = 0; c < N_CH; c++) begin
                            acc[c] <= '0;
                        end
                    end
                end
                ACC: begin
                    for (int c = 0; c < N_CH; c++) begin
                        acc[c] <= acc[c] + prod[c];
                    end
                    if (tap_idx == TAP_W'(N_TAP - 1)) begin
                        state <= WR;
                    end else begin
                        tap_idx <= tap_idx + TAP_W'(1);
                    end
                end
                WR: begin
                    state   <= IDLE;
                    bsy     <= 1'b0;
                    tap_idx <= '0;
                    wr_addr <= wr_addr + AW'(1);
                    rdy     <= (wr_addr == AW'(DEPTH - 1));
                end
                default: begin
                    state <= IDLE;
                    bsy   <= 1'b0;
                end
            endcase
        end
    end

    conv_out_ram #(
        .DEPTH (DEPTH),
        .WIDTH (N_CH * OUT_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_word),
        .raddr (rd_addr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_conv_layer_acc.sv
// Bench for conv_layer_acc: a default instance (a) and a small one with
// OUT_W=8, DEPTH=4 (b) share stimulus; a scoreboard checks stored words.
module tb_conv_layer_acc;

    localparam int unsigned N_CH    = 2;
    localparam int unsigned N_TAP   = 9;
    localparam int unsigned OUT_A   = 18;
    localparam int unsigned OUT_B   = 8;
    localparam int unsigned DEPTH_A = 676;
    localparam int unsigned DEPTH_B = 4;
    localparam int unsigned AW_A    = $clog2(DEPTH_A + 1);
    localparam int unsigned AW_B    = $clog2(DEPTH_B + 1);

    typedef struct {
        int          addr;
        logic [63:0] val;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               strt;
    logic               tx_done;
    logic               din;
    logic               wt_wr;
    logic               wt_ch;
    logic [3:0]         wt_tap;
    logic signed [8:0]  wt_data;
    logic [AW_A-1:0]    rd_addr_a;
    logic [AW_B-1:0]    rd_addr_b;
    logic [3:0]         tap_a;
    logic [3:0]         tap_b;
    logic               bsy_a;
    logic               bsy_b;
    logic               rdy_a;
    logic               rdy_b;
    logic [35:0]        dout_a;
    logic [15:0]        dout_b;
    logic [15:0]        pix_cur;

    // Window feeder follows the tap index the DUT asks for
    assign din = pix_cur[tap_a];

    always #5 clk = ~clk;

    conv_layer_acc u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .strt    (strt),
        .tx_done (tx_done),
        .din     (din),
        .tap_idx (tap_a),
        .bsy     (bsy_a),
        .rdy     (rdy_a),
        .wt_wr   (wt_wr),
        .wt_ch   (wt_ch),
        .wt_tap  (wt_tap),
        .wt_data (wt_data),
        .rd_addr (rd_addr_a),
        .dout    (dout_a)
    );

    conv_layer_acc #(
        .OUT_W (OUT_B),
        .DEPTH (DEPTH_B)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .strt    (strt),
        .tx_done (tx_done),
        .din     (din),
        .tap_idx (tap_b),
        .bsy     (bsy_b),
        .rdy     (rdy_b),
        .wt_wr   (wt_wr),
        .wt_ch   (wt_ch),
        .wt_tap  (wt_tap),
        .wt_data (wt_data),
        .rd_addr (rd_addr_b),
        .dout    (dout_b)
    );

    // Reference model state
    int   w_m    [N_CH][N_TAP];
    int   bias_m [N_CH];
    int   addr_a;
    int   addr_b;
    bit   rdy_bm;
    logic [63:0] mem_a [int];
    logic [63:0] mem_b [int];
    exp_t exp_qa [$];
    exp_t exp_qb [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sat_ref(input int s, input int out_w);
        int mx;
        mx = (1 << out_w) - 1;
        if (s <= 0) return 64'd0;
        if (s > mx) return 64'(mx);
        return 64'(s);
    endfunction

    function automatic int dot(input int c, input logic [8:0] pix);
        int s;
        s = bias_m[c];
        for (int t = 0; t < N_TAP; t++) begin
            if (pix[t]) s += w_m[c][t];
        end
        return s;
    endfunction

    task automatic load(input int c, input int t, input int v);
        @(negedge clk);
        wt_wr   = 1'b1;
        wt_ch   = c[0];
        wt_tap  = t[3:0];
        wt_data = v[8:0];
        @(negedge clk);
        wt_wr = 1'b0;
        if (c < N_CH && t <= N_TAP) begin
            if (t == N_TAP) bias_m[c] = v;
            else w_m[c][t] = v;
        end
    endtask

    task automatic load_ch(input int c, input int v, input int b);
        for (int t = 0; t < N_TAP; t++) load(c, t, v);
        load(c, N_TAP, b);
    endtask

    // One output position; abort_kind 1 = tx_done, 2 = rst (with strt held) at abort_tap
    task automatic run_pos(input logic [8:0] pix, input int abort_tap,
                           input int abort_kind, input bit busy_wr);
        bit          b_on;
        logic [63:0] va;
        logic [63:0] vb;
        exp_t        e;
        b_on = !rdy_bm;
        va = (sat_ref(dot(1, pix), OUT_A) << OUT_A) | sat_ref(dot(0, pix), OUT_A);
        vb = (sat_ref(dot(1, pix), OUT_B) << OUT_B) | sat_ref(dot(0, pix), OUT_B);
        pix_cur = {7'd0, pix};
        @(negedge clk);
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
        for (int t = 0; t < N_TAP; t++) begin
            check("tap_idx_a", tap_a, t);
            check("tap_idx_b", tap_b, b_on ? t : 0);
            check("bsy_a_acc", bsy_a, 1);
            check("bsy_b_acc", bsy_b, b_on);
            wt_wr = busy_wr && (t == 2);
            wt_ch = 1'b0;
            wt_tap = 4'd0;
            wt_data = 9'sd77;
            strt = busy_wr && (t == 5);
            if (t == abort_tap) begin
                if (abort_kind == 1) begin
                    tx_done = 1'b1;
                end else begin
                    rst  = 1'b1;
                    strt = 1'b1;
                end
                @(negedge clk);
                check("abort_bsy_a", bsy_a, 0);
                check("abort_bsy_b", bsy_b, 0);
                check("abort_tap_a", tap_a, 0);
                check("abort_rdy_b", rdy_b, 0);
                if (abort_kind == 2) begin
                    check("rst_dout_a", dout_a, 0);
                    check("rst_dout_b", dout_b, 0);
                    check("rst_rdy_a", rdy_a, 0);
                end
                tx_done = 1'b0;
                rst     = 1'b0;
                strt    = 1'b0;
                addr_a  = 0;
                addr_b  = 0;
                rdy_bm  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        wt_wr = 1'b0;
        strt  = 1'b0;
        check("bsy_a_wr", bsy_a, 1);
        check("bsy_b_wr", bsy_b, b_on);
        @(negedge clk);
        check("bsy_a_done", bsy_a, 0);
        check("bsy_b_done", bsy_b, 0);
        e.addr = addr_a;
        e.val  = va;
        exp_qa.push_back(e);
        mem_a[addr_a] = va;
        addr_a++;
        if (b_on) begin
            e.addr = addr_b;
            e.val  = vb;
            exp_qb.push_back(e);
            mem_b[addr_b] = vb;
            addr_b++;
            if (addr_b == DEPTH_B) rdy_bm = 1'b1;
        end
        check("rdy_a", rdy_a, 0);
        check("rdy_b", rdy_b, rdy_bm);
    endtask

    // Pop every pending expected write and read it back
    task automatic drain();
        exp_t e;
        while (exp_qa.size() > 0) begin
            e = exp_qa.pop_front();
            @(negedge clk);
            rd_addr_a = AW_A'(e.addr);
            @(negedge clk);
            check("dout_a", dout_a, e.val);
        end
        while (exp_qb.size() > 0) begin
            e = exp_qb.pop_front();
            @(negedge clk);
            rd_addr_b = AW_B'(e.addr);
            @(negedge clk);
            check("dout_b", dout_b, e.val);
        end
    endtask

    task automatic read_a(input string tag, input int addr, input logic [63:0] exp);
        @(negedge clk);
        rd_addr_a = AW_A'(addr);
        @(negedge clk);
        check(tag, dout_a, exp);
    endtask

    task automatic read_b(input string tag, input int addr, input logic [63:0] exp);
        @(negedge clk);
        rd_addr_b = AW_B'(addr);
        @(negedge clk);
        check(tag, dout_b, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        strt      = 1'b0;
        tx_done   = 1'b0;
        wt_wr     = 1'b0;
        wt_ch     = 1'b0;
        wt_tap    = 4'd0;
        wt_data   = 9'sd0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        pix_cur   = 16'd0;
        addr_a    = 0;
        addr_b    = 0;
        rdy_bm    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_bsy_a", bsy_a, 0);
        check("reset_rdy_a", rdy_a, 0);
        check("reset_tap_a", tap_a, 0);
        check("reset_dout_a", dout_a, 0);
        check("reset_bsy_b", bsy_b, 0);
        check("reset_rdy_b", rdy_b, 0);
        check("reset_dout_b", dout_b, 0);
        rst = 1'b0;

        // Unit weights, zero bias: both channels sum to 9
        load_ch(0, 1, 0);
        load_ch(1, 1, 0);
        run_pos(9'h1FF, -1, 0, 1'b0);
        drain();

        // Negative bias on channel 1 clamps it to 0
        load(1, N_TAP, -20);
        run_pos(9'h1FF, -1, 0, 1'b0);
        drain();

        // Large weights: 2295 stays in a, saturates to 255 in b
        load_ch(0, 255, 0);
        load_ch(1, 255, 0);
        run_pos(9'h1FF, -1, 0, 1'b0);
        drain();

        // Mixed signed weights and sparse pixels; fills b, so rdy_b rises
        for (int t = 0; t < N_TAP; t++) begin
            load(0, t, t - 4);
            load(1, t, 3 * t);
        end
        load(0, N_TAP, 7);
        load(1, N_TAP, -30);
        run_pos(9'b101010101, -1, 0, 1'b0);
        drain();

        // Fifth position: a writes, b is full and must ignore strt
        run_pos(9'h0F0, -1, 0, 1'b0);
        drain();
        read_b("b_full_keep", 3, mem_b[3]);
        read_b("b_oob_read", DEPTH_B, 64'd0);
        read_a("a_oob_read", DEPTH_A, 64'd0);

        // Frame consumed: rdy drops, addresses restart
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("txd_rdy_b", rdy_b, 0);
        addr_a = 0;
        addr_b = 0;
        rdy_bm = 1'b0;

        // Abort at tap 4: nothing written, address 0 keeps its old word
        run_pos(9'h1FF, 4, 1, 1'b0);
        read_a("abort_keep_a", 0, mem_a[0]);
        read_b("abort_keep_b", 0, mem_b[0]);

        // Out-of-range tap write and a write during busy are both dropped
        load(0, 12, 100);
        run_pos(9'h1FF, -1, 0, 1'b1);
        drain();
        read_a("addr1_keep_a", 1, mem_a[1]);

        // Reset mid-accumulation; weight tables survive
        run_pos(9'h1FF, 4, 2, 1'b0);
        run_pos(9'h0FF, -1, 0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
